temporizer_ctrl: RTL and testbench
==================================

# temporizer_ctrl

Countdown-timer controller for the temporizer. Consumes the slow one-second level signal from the clock divider, sequences a start/pause/clear countdown over a BCD MM:SS value, and drives alarm and status signals to the VGA display path. Sits between the button front end (debounced, one-cycle pulses) and the display renderer.

## Interface
- ALARM_SECS, 10, number of one-second ticks the alarm stays asserted in DONE before auto-return to IDLE; range 1..255
- clk  in  1  system clock, same domain as the clock divider
- rst_n  in  1  asynchronous, active-low reset
- sec_in  in  1  one-second level from the divider; each rising edge counts as one tick
- btn_start  in  1  one-cycle pulse: start or resume
- btn_stop  in  1  one-cycle pulse: pause
- btn_clear  in  1  one-cycle pulse: abort and zero
- set_en  in  1  one-cycle pulse: load set_mm/set_ss
- set_mm  in  8  BCD minutes, 00..99
- set_ss  in  8  BCD seconds, 00..59
- mm  out  8  current BCD minutes
- ss  out  8  current BCD seconds
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
- alarm  out  1  high while in DONE
- done_pulse  out  1  one cycle on entry to DONE
- load_err  out  1  one cycle when a load is rejected

## Operation
- Tick: tick = sec_in & ~sec_q. sec_q is a register of sec_in, reset to 1, so a sec_in already high at reset release does not produce a tick.
- Command priority within one cycle: clear > stop > start > load > tick. A command present in a cycle consumes that cycle's tick; the tick is discarded, not deferred.
- IDLE:
  - set_en with valid BCD loads mm/ss.
  - start with a nonzero value goes to RUN; start at 00:00 is ignored.
  - clear zeroes mm/ss.
- RUN:
  - Each tick decrements MM:SS by one second with BCD borrow (ss 00 wraps to 59 and mm decrements).
  - The tick that takes the value from 00:01 to 00:00 moves to DONE and asserts done_pulse.
  - stop goes to PAUSE. clear goes to IDLE with value 00:00. set_en is ignored.
- PAUSE:
  - Ticks are ignored.
  - start goes to RUN.
  - clear goes to IDLE and zeroes mm/ss.
  - set_en with valid BCD loads mm/ss and stays in PAUSE; if the loaded value is 00:00, a later start is ignored.
- DONE:
  - alarm=1 and the alarm counter counts ticks.
  - After ALARM_SECS ticks, or on start or clear, go to IDLE. mm/ss remain 00:00.
- Load validation: reject the load if any units digit > 9, mm tens > 9, or ss tens > 5. A rejected load leaves mm/ss unchanged and asserts load_err for one cycle. load_err also fires for an invalid load attempted in RUN or DONE; in those states a valid set_en does nothing.
- Reset values: mm=00, ss=00, state=IDLE, alarm=0, done_pulse=0, load_err=0, alarm counter=0.
- Reset mid-operation returns everything to the reset values immediately (asynchronous assert). Deassertion is clean and synchronous to clk.

## Timing
- All outputs are registered.
- Command pulse sampled at edge N: state/mm/ss update at edge N; new values are visible from cycle N+1.
- Tick: sec_in sampled high at edge N with sec_q=0 gives the decrement visible after edge N. Latency is 1 cycle from sampled rise.
- done_pulse is high exactly in the cycle where state first reads DONE.
- 99:59 takes 5999 ticks to reach 00:00.
- Back-to-back commands on consecutive cycles are each honored.

## Structure
- Shared package temporizer_pkg holds:
  - state enum (IDLE/RUN/PAUSE/DONE, 2-bit)
  - BCD digit typedef (4-bit)
  - MMSS struct
  - constants MAX_MM_TENS=9 and MAX_SS_TENS=5
- One sub-module, bcd_mmss_dec: combinational MM:SS BCD decrement with an is_one flag (value == 00:01) and a valid flag for load checking. The controller instantiates it once for the decrement and once for validation, or shares it.
- FSM and alarm counter live in temporizer_ctrl.

## Test plan
- Reset with sec_in=1, release, hold sec_in high -> no tick; mm=00, ss=00, state=IDLE.
- Load 01:05, start, 6 ticks -> ss sequence 04,03,02,01,00,59 with mm=00 after the sixth; 59 more ticks -> DONE, done_pulse for 1 cycle, alarm=1; 10 more ticks -> IDLE, alarm=0.
- Load 00:03, start, 1 tick, stop together with a tick -> PAUSE at 00:02; 5 ticks -> stays 00:02; start, 2 ticks -> DONE.
- Load set_ss=8'h60 -> load_err pulse, value unchanged; load 00:00 then start -> stays IDLE.
- In RUN at 12:34, clear and tick in the same cycle -> IDLE, 00:00, no decrement observed.
- Load 99:59, run 5999 ticks -> DONE exactly on tick 5999, with no glitch at the mm decrement boundaries.

Source files
------------

// File: rtl/temporizer_pkg.sv
// Shared types and constants for the temporizer countdown controller.
package temporizer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t mm_t;
        bcd_t mm_u;
        bcd_t ss_t;
        bcd_t ss_u;
    } mmss_t;

    localparam bcd_t MAX_MM_TENS = 4'd9;
    localparam bcd_t MAX_SS_TENS = 4'd5;
    localparam bcd_t MAX_UNITS   = 4'd9;

    localparam mmss_t MMSS_ZERO = '0;
    localparam mmss_t MMSS_ONE  = 16'h0001;

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational MM:SS BCD decrement, 00:01 detect and digit-range check.
module bcd_mmss_dec
    import temporizer_pkg::*;
(
    input  mmss_t val_i,
    output mmss_t dec_o,
    output logic  is_one_o,
    output logic  valid_o
);

    always_comb begin
        dec_o = val_i;
        if (val_i.ss_u != 4'd0) begin
            dec_o.ss_u = val_i.ss_u - 4'd1;
        end else begin
            dec_o.ss_u = MAX_UNITS;
            if (val_i.ss_t != 4'd0) begin
                dec_o.ss_t = val_i.ss_t - 4'd1;
            end else begin
                dec_o.ss_t = MAX_SS_TENS;
                if (val_i.mm_u != 4'd0) begin
                    dec_o.mm_u = val_i.mm_u - 4'd1;
                end else begin
                    dec_o.mm_u = MAX_UNITS;
                    dec_o.mm_t = val_i.mm_t - 4'd1;
                end
            end
        end
    end

    assign is_one_o = (val_i == MMSS_ONE);

    assign valid_o = (val_i.mm_t <= MAX_MM_TENS) &&
                     (val_i.mm_u <= MAX_UNITS) &&
                     (val_i.ss_t <= MAX_SS_TENS) &&
                     (val_i.ss_u <= MAX_UNITS);

endmodule

// File: rtl/temporizer_ctrl.sv
// Countdown-timer FSM: start/pause/clear over BCD MM:SS with a timed alarm.
module temporizer_ctrl
    import temporizer_pkg::*;
#(
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_in,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
    input  logic       set_en,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic [1:0] state,
    output logic       alarm,
    output logic       done_pulse,
    output logic       load_err
);

    localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECS - 1);

    state_e     state_q;
    mmss_t      val_q;
    logic       sec_q;
    logic       alarm_q;
    logic       done_q;
    logic       err_q;
    logic [7:0] cnt_q;

    mmss_t dec_in;
    mmss_t dec_val;
    logic  is_one;
    logic  valid;
    logic  tick;
    logic  nonzero;

    // A load consumes the tick, so one decoder serves both roles.
    assign dec_in  = set_en ? mmss_t'({set_mm, set_ss}) : val_q;
    assign tick    = sec_in & ~sec_q;
    assign nonzero = (val_q != MMSS_ZERO);

    bcd_mmss_dec u_dec (
        .val_i    (dec_in),
        .dec_o    (dec_val),
        .is_one_o (is_one),
        .valid_o  (valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q   <= 1'b1;
            state_q <= ST_IDLE;
            val_q   <= MMSS_ZERO;
            alarm_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            sec_q  <= sec_in;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (btn_clear) begin
                        val_q <= MMSS_ZERO;
                    end else if (btn_stop) begin
                        state_q <= ST_IDLE;
                    end else if (btn_start) begin
                        if (nonzero) state_q <= ST_RUN;
                    end else if (set_en) begin
                        if (valid) val_q <= dec_in;
                        else       err_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (btn_clear) begin
                        state_q <= ST_IDLE;
                        val_q   <= MMSS_ZERO;
                    end else if (btn_stop) begin
                        state_q <= ST_PAUSE;
                    end else if (btn_start) begin
                        state_q <= ST_RUN;
                    end else if (set_en) begin
                        err_q <= ~valid;
                    end else if (tick) begin
                        val_q <= dec_val;
                        if (is_one) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            alarm_q <= 1'b1;
                            cnt_q   <= 8'd0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (btn_clear) begin
                        state_q <= ST_IDLE;
                        val_q   <= MMSS_ZERO;
                    end else if (btn_stop) begin
                        state_q <= ST_PAUSE;
                    end else if (btn_start) begin
                        if (nonzero) state_q <= ST_RUN;
                    end else if (set_en) begin
                        if (valid) val_q <= dec_in;
                        else       err_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (btn_clear || btn_start) begin
                        state_q <= ST_IDLE;
                        alarm_q <= 1'b0;
                        cnt_q   <= 8'd0;
                    end else if (btn_stop) begin
                        state_q <= ST_DONE;
                    end else if (set_en) begin
                        err_q <= ~valid;
                    end else if (tick) begin
                        if (cnt_q == ALARM_LAST) begin
                            state_q <= ST_IDLE;
                            alarm_q <= 1'b0;
                            cnt_q   <= 8'd0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mm         = {val_q.mm_t, val_q.mm_u};
    assign ss         = {val_q.ss_t, val_q.ss_u};
    assign state      = state_q;
    assign alarm      = alarm_q;
    assign done_pulse = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_temporizer_ctrl.sv
// Directed vector table plus corner-case sequences for temporizer_ctrl.
module tb_temporizer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sec_in;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_clear;
    logic       set_en;
    logic [7:0] set_mm;
    logic [7:0] set_ss;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [1:0] state;
    logic       alarm;
    logic       done_pulse;
    logic       load_err;

    int errs   = 0;
    int checks = 0;

    temporizer_ctrl #(.ALARM_SECS(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sec_in     (sec_in),
        .btn_start  (btn_start),
        .btn_stop   (btn_stop),
        .btn_clear  (btn_clear),
        .set_en     (set_en),
        .set_mm     (set_mm),
        .set_ss     (set_ss),
        .mm         (mm),
        .ss         (ss),
        .state      (state),
        .alarm      (alarm),
        .done_pulse (done_pulse),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, sp, cl, se;
        logic [7:0] smm, sss;
        logic       sec;
        logic [7:0] emm, ess;
        logic [1:0] est;
        logic       eal, edp, ele;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(
        input logic st, input logic sp, input logic cl, input logic se,
        input logic [7:0] smm, input logic [7:0] sss, input logic sec,
        input logic [7:0] emm, input logic [7:0] ess, input logic [1:0] est,
        input logic eal, input logic edp, input logic ele);
        vec_t r;
        r.st = st; r.sp = sp; r.cl = cl; r.se = se;
        r.smm = smm; r.sss = sss; r.sec = sec;
        r.emm = emm; r.ess = ess; r.est = est;
        r.eal = eal; r.edp = edp; r.ele = ele;
        return r;
    endfunction

    function automatic logic [7:0] bcd(input int x);
        logic [7:0] r;
        r[7:4] = 4'(x / 10);
        r[3:0] = 4'(x % 10);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0] emm,
                           input logic [7:0] ess, input logic [1:0] est,
                           input logic eal, input logic edp, input logic ele);
        chk({nm, ".mm"}, 16'(mm), 16'(emm));
        chk({nm, ".ss"}, 16'(ss), 16'(ess));
        chk({nm, ".state"}, 16'(state), 16'(est));
        chk({nm, ".alarm"}, 16'(alarm), 16'(eal));
        chk({nm, ".done"}, 16'(done_pulse), 16'(edp));
        chk({nm, ".err"}, 16'(load_err), 16'(ele));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        btn_start = 0; btn_stop = 0; btn_clear = 0; set_en = 0;
        set_mm = 8'h00; set_ss = 8'h00;
    endtask

    task automatic load(input logic [7:0] m, input logic [7:0] s);
        set_en = 1; set_mm = m; set_ss = s;
        cyc();
        idle_in();
    endtask

    task automatic start();
        btn_start = 1;
        cyc();
        idle_in();
    endtask

    task automatic clear();
        btn_clear = 1;
        cyc();
        idle_in();
    endtask

    // Leaves sec_in high; outputs reflect the tick when this returns.
    task automatic tick();
        sec_in = 0;
        cyc();
        sec_in = 1;
        cyc();
    endtask

    initial begin
        rst_n = 0;
        sec_in = 1;
        idle_in();
        repeat (3) cyc();
        chk_all("reset", 8'h00, 8'h00, 2'd0, 0, 0, 0);
        rst_n = 1;
        repeat (3) cyc();
        chk_all("post_reset", 8'h00, 8'h00, 2'd0, 0, 0, 0);
        load(8'h00, 8'h05);
        start();
        repeat (3) cyc();
        chk_all("sec_high_no_tick", 8'h00, 8'h05, 2'd1, 0, 0, 0);
        clear();
        sec_in = 0;
        cyc();

        tv.push_back(v(0,0,0,1, 8'h01,8'h05, 0, 8'h01,8'h05, 2'd0, 0,0,0));
        tv.push_back(v(1,0,0,0, 8'h00,8'h00, 0, 8'h01,8'h05, 2'd1, 0,0,0));
        tv.push_back(v(0,0,0,0, 8'h00,8'h00, 1, 8'h01,8'h04, 2'd1, 0,0,0));
        tv.push_back(v(0,0,0,0, 8'h00,8'h00, 1, 8'h01,8'h03, 2'd1, 0,0,0));
        tv.push_back(v(0,0,0,0, 8'h00,8'h00, 1, 8'h01,8'h02, 2'd1, 0,0,0));
        tv.push_back(v(0,0,0,0, 8'h00,8'h00, 1, 8'h01,8'h01, 2'd1, 0,0,0));
        tv.push_back(v(0,0,0,0, 8'h00,8'h00, 1, 8'h01,8'h00, 2'd1, 0,0,0));
        tv.push_back(v(0,0,0,0, 8'h00,8'h00, 1, 8'h00,8'h59, 2'd1, 0,0,0));
        tv.push_back(v(0,0,0,1, 8'h00,8'h10, 0, 8'h00,8'h59, 2'd1, 0,0,0));
        tv.push_back(v(0,0,0,1, 8'h00,8'h60, 0, 8'h00,8'h59, 2'd1, 0,0,1));
        tv.push_back(v(0,1,0,0, 8'h00,8'h00, 1, 8'h00,8'h59, 2'd2, 0,0,0));
        tv.push_back(v(0,0,0,0, 8'h00,8'h00, 1, 8'h00,8'h59, 2'd2, 0,0,0));
        tv.push_back(v(0,0,0,1, 8'h00,8'h60, 0, 8'h00,8'h59, 2'd2, 0,0,1));
        tv.push_back(v(0,0,0,1, 8'hA0,8'h00, 0, 8'h00,8'h59, 2'd2, 0,0,1));
        tv.push_back(v(0,0,0,1, 8'h00,8'h02, 0, 8'h00,8'h02, 2'd2, 0,0,0));
        tv.push_back(v(1,0,0,0, 8'h00,8'h00, 0, 8'h00,8'h02, 2'd1, 0,0,0));
        tv.push_back(v(0,0,0,0, 8'h00,8'h00, 1, 8'h00,8'h01, 2'd1, 0,0,0));
        tv.push_back(v(0,0,0,0, 8'h00,8'h00, 1, 8'h00,8'h00, 2'd3, 1,1,0));
        tv.push_back(v(1,0,0,0, 8'h00,8'h00, 0, 8'h00,8'h00, 2'd0, 0,0,0));
        tv.push_back(v(1,0,0,0, 8'h00,8'h00, 0, 8'h00,8'h00, 2'd0, 0,0,0));
        tv.push_back(v(0,0,0,1, 8'h12,8'h34, 0, 8'h12,8'h34, 2'd0, 0,0,0));
        tv.push_back(v(1,0,0,0, 8'h00,8'h00, 0, 8'h12,8'h34, 2'd1, 0,0,0));
        tv.push_back(v(0,0,1,0, 8'h00,8'h00, 1, 8'h00,8'h00, 2'd0, 0,0,0));
        tv.push_back(v(0,0,0,1, 8'h12,8'h34, 0, 8'h12,8'h34, 2'd0, 0,0,0));
        tv.push_back(v(1,0,0,1, 8'h00,8'h00, 0, 8'h12,8'h34, 2'd1, 0,0,0));
        tv.push_back(v(0,0,1,0, 8'h00,8'h00, 0, 8'h00,8'h00, 2'd0, 0,0,0));
        tv.push_back(v(0,0,0,1, 8'h0A,8'h00, 0, 8'h00,8'h00, 2'd0, 0,0,1));
        tv.push_back(v(0,0,0,1, 8'h00,8'h0F, 0, 8'h00,8'h00, 2'd0, 0,0,1));
        tv.push_back(v(0,0,0,1, 8'h00,8'h00, 0, 8'h00,8'h00, 2'd0, 0,0,0));
        tv.push_back(v(1,0,0,0, 8'h00,8'h00, 0, 8'h00,8'h00, 2'd0, 0,0,0));

        foreach (tv[i]) begin
            btn_start = tv[i].st;
            btn_stop  = tv[i].sp;
            btn_clear = tv[i].cl;
            set_en    = tv[i].se;
            set_mm    = tv[i].smm;
            set_ss    = tv[i].sss;
            sec_in    = tv[i].sec;
            cyc();
            chk_all($sformatf("vec%0d", i), tv[i].emm, tv[i].ess,
                    tv[i].est, tv[i].eal, tv[i].edp, tv[i].ele);
            idle_in();
            sec_in = 0;
            cyc();
        end

        // 01:05 to DONE after 65 ticks, then the 10-tick alarm window.
        load(8'h01, 8'h05);
        start();
        for (int i = 1; i <= 65; i++) begin
            tick();
            if (i < 65) chk("a_run", 16'(state), 16'd1);
        end
        chk_all("a_done", 8'h00, 8'h00, 2'd3, 1, 1, 0);
        cyc();
        chk_all("a_done_next", 8'h00, 8'h00, 2'd3, 1, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i < 10) chk("a_alarm_hold", 16'(alarm), 16'd1);
        end
        chk_all("a_auto_idle", 8'h00, 8'h00, 2'd0, 0, 0, 0);

        // Stop coinciding with a tick pauses without decrementing.
        load(8'h00, 8'h03);
        start();
        tick();
        chk_all("b_tick1", 8'h00, 8'h02, 2'd1, 0, 0, 0);
        sec_in = 0;
        cyc();
        sec_in = 1;
        btn_stop = 1;
        cyc();
        idle_in();
        chk_all("b_stop_tick", 8'h00, 8'h02, 2'd2, 0, 0, 0);
        repeat (5) tick();
        chk_all("b_paused", 8'h00, 8'h02, 2'd2, 0, 0, 0);
        start();
        tick();
        chk_all("b_resume", 8'h00, 8'h01, 2'd1, 0, 0, 0);
        tick();
        chk_all("b_done", 8'h00, 8'h00, 2'd3, 1, 1, 0);
        clear();
        chk_all("b_clear", 8'h00, 8'h00, 2'd0, 0, 0, 0);

        // Full-range countdown against an integer seconds model.
        load(8'h99, 8'h59);
        start();
        for (int n = 5998; n >= 0; n--) begin
            tick();
            chk("c_mm", 16'(mm), 16'(bcd(n / 60)));
            chk("c_ss", 16'(ss), 16'(bcd(n % 60)));
            chk("c_state", 16'(state), (n == 0) ? 16'd3 : 16'd1);
        end
        chk("c_done_pulse", 16'(done_pulse), 16'd1);
        clear();

        // Asynchronous reset mid-run takes effect without a clock edge.
        load(8'h12, 8'h34);
        start();
        tick();
        chk_all("d_run", 8'h12, 8'h33, 2'd1, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        chk_all("d_async_rst", 8'h00, 8'h00, 2'd0, 0, 0, 0);
        cyc();
        rst_n = 1;
        cyc();
        start();
        chk_all("d_after_rst", 8'h00, 8'h00, 2'd0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
